// File: rtl/nvram_seq_gen.sv
// NVRAM memory-cycle sequence generator: programmable setup/strobe/hold
// phases, wait-state extension and busy/done/error handshake.
module nvram_seq_gen #(
    parameter int NUM_CS = 2,
    parameter int CS_W   = 1,
    parameter int CNT_W  = 3
) (
    input  logic              Clk,
    input  logic              Reset_N,
    input  logic              StartCycle,
    input  logic              ReadSeq,
    input  logic              WriteSeq,
    input  logic [CS_W-1:0]   ChipSel,
    input  logic [CNT_W-1:0]  SetupCnt,
    input  logic [CNT_W-1:0]  StrobeCnt,
    input  logic [CNT_W-1:0]  HoldCnt,
    input  logic              Extend,
    output logic [NUM_CS-1:0] CE_N,
    output logic              WE_N,
    output logic              OE_N,
    output logic              Busy,
    output logic              Done,
    output logic              Error,
    output logic [2:0]        SeqState
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_STROBE = 3'd2,
        S_HOLD   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [CS_W:0] LP_NCS = (CS_W + 1)'(NUM_CS);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_strobe_cnt;
    logic [CNT_W-1:0]  r_hold_cnt;
    logic [CS_W-1:0]   r_sel;
    logic              r_rd;
    logic              r_abort;
    logic              r_err_lock;
    logic [NUM_CS-1:0] r_ce_n;
    logic              r_we_n;
    logic              r_oe_n;
    logic              r_busy;
    logic              r_done;
    logic              r_error;

    logic w_sel_ok;
    logic w_one_seq;
    logic w_both_seq;
    logic w_illegal;
    logic w_legal;
    logic w_cnt_zero;

    assign w_sel_ok   = {1'b0, ChipSel} < LP_NCS;
    assign w_one_seq  = ReadSeq ^ WriteSeq;
    assign w_both_seq = ReadSeq & WriteSeq;
    assign w_illegal  = w_both_seq | (w_one_seq & ~w_sel_ok);
    assign w_legal    = w_one_seq & w_sel_ok;
    assign w_cnt_zero = (r_cnt == '0);

    function automatic logic [NUM_CS-1:0] ce_mask(input logic [CS_W-1:0] sel);
        logic [NUM_CS-1:0] m;
        m = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (sel == CS_W'(i)) m[i] = 1'b0;
        end
        return m;
    endfunction

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_strobe_cnt <= '0;
            r_hold_cnt   <= '0;
            r_sel        <= '0;
            r_rd         <= 1'b0;
            r_abort      <= 1'b0;
            r_err_lock   <= 1'b0;
            r_ce_n       <= '1;
            r_we_n       <= 1'b1;
            r_oe_n       <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            if (!StartCycle) r_err_lock <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (StartCycle && w_illegal && !r_err_lock) begin
                        r_error    <= 1'b1;
                        r_err_lock <= 1'b1;
                    end else if (StartCycle && w_legal) begin
                        r_rd         <= ReadSeq;
                        r_sel        <= ChipSel;
                        r_strobe_cnt <= StrobeCnt;
                        r_hold_cnt   <= HoldCnt;
                        r_cnt        <= SetupCnt;
                        r_abort      <= 1'b0;
                        r_state      <= S_SETUP;
                        r_ce_n       <= ce_mask(ChipSel);
                        r_oe_n       <= ~ReadSeq;
                        r_we_n       <= 1'b1;
                        r_busy       <= 1'b1;
                    end
                end
                S_SETUP: begin
                    if (!StartCycle) begin
                        r_state <= S_IDLE;
                        r_ce_n  <= '1;
                        r_oe_n  <= 1'b1;
                        r_we_n  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else if (w_cnt_zero) begin
                        r_state <= S_STROBE;
                        r_cnt   <= r_strobe_cnt;
                        r_we_n  <= r_rd;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_STROBE: begin
                    // Abort still runs the full hold phase to protect data hold time
                    if (!StartCycle || (w_cnt_zero && !Extend)) begin
                        r_state <= S_HOLD;
                        r_cnt   <= r_hold_cnt;
                        r_abort <= ~StartCycle;
                        r_we_n  <= 1'b1;
                        r_oe_n  <= 1'b1;
                    end else if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!StartCycle) r_abort <= 1'b1;
                    if (w_cnt_zero) begin
                        r_ce_n <= '1;
                        r_busy <= 1'b0;
                        if (r_abort || !StartCycle) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    if (!StartCycle) r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ce_n  <= '1;
                    r_we_n  <= 1'b1;
                    r_oe_n  <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign CE_N     = r_ce_n;
    assign WE_N     = r_we_n;
    assign OE_N     = r_oe_n;
    assign Busy     = r_busy;
    assign Done     = r_done;
    assign Error    = r_error;
    assign SeqState = r_state;

endmodule

// File: tb/tb_nvram_seq_gen.sv
// Directed scoreboard bench for nvram_seq_gen: strobe widths, handshake
// pulses, extend, illegal requests, aborts and async reset.
module tb_nvram_seq_gen;

    logic       Clk        = 1'b0;
    logic       Reset_N    = 1'b1;
    logic       StartCycle = 1'b0;
    logic       ReadSeq    = 1'b0;
    logic       WriteSeq   = 1'b0;
    logic [0:0] ChipSel    = 1'b0;
    logic [2:0] SetupCnt   = 3'd0;
    logic [2:0] StrobeCnt  = 3'd0;
    logic [2:0] HoldCnt    = 3'd0;
    logic       Extend     = 1'b0;
    logic [1:0] CE_N;
    logic       WE_N;
    logic       OE_N;
    logic       Busy;
    logic       Done;
    logic       Error;
    logic [2:0] SeqState;

    int checks = 0;
    int errors = 0;

    nvram_seq_gen #(.NUM_CS(2), .CS_W(1), .CNT_W(3)) dut (
        .Clk(Clk), .Reset_N(Reset_N), .StartCycle(StartCycle),
        .ReadSeq(ReadSeq), .WriteSeq(WriteSeq), .ChipSel(ChipSel),
        .SetupCnt(SetupCnt), .StrobeCnt(StrobeCnt), .HoldCnt(HoldCnt),
        .Extend(Extend), .CE_N(CE_N), .WE_N(WE_N), .OE_N(OE_N),
        .Busy(Busy), .Done(Done), .Error(Error), .SeqState(SeqState)
    );

    always #5 Clk = ~Clk;

    // Monitor: cycle counts of each output condition, sampled on falling edge
    int m_cyc = 0, m_ce = 0, m_oe = 0, m_we = 0, m_done = 0, m_err = 0;
    int m_busy = 0, m_hold = 0, m_inv = 0, m_ce_fall = 0, m_we_fall = 0;
    logic [1:0] p_ce = 2'b11;
    logic       p_we = 1'b1;

    always @(negedge Clk) begin
        m_cyc++;
        if (CE_N !== 2'b11) m_ce++;
        if (OE_N === 1'b0) m_oe++;
        if (WE_N === 1'b0) m_we++;
        if (Done === 1'b1) m_done++;
        if (Error === 1'b1) m_err++;
        if (Busy === 1'b1) m_busy++;
        if (SeqState === 3'd3) m_hold++;
        if ($countones(~CE_N) > 1) m_inv++;
        if (WE_N === 1'b0 && OE_N === 1'b0) m_inv++;
        if (WE_N === 1'b0 && CE_N === 2'b11) m_inv++;
        if (p_ce === 2'b11 && CE_N !== 2'b11) m_ce_fall = m_cyc;
        if (p_we === 1'b1 && WE_N === 1'b0) m_we_fall = m_cyc;
        p_ce = CE_N;
        p_we = WE_N;
    end

    int b_ce, b_oe, b_we, b_done, b_err, b_busy, b_hold;

    typedef struct {
        string tag;
        int    ce;
        int    oe;
        int    we;
        int    dn;
        int    er;
    } exp_t;

    exp_t sbq[$];

    task automatic tick();
        @(negedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input string t, input int ce, input int oe,
                        input int we, input int dn, input int er);
        exp_t e;
        e.tag = t; e.ce = ce; e.oe = oe; e.we = we; e.dn = dn; e.er = er;
        sbq.push_back(e);
        b_ce = m_ce; b_oe = m_oe; b_we = m_we; b_done = m_done;
        b_err = m_err; b_busy = m_busy; b_hold = m_hold;
    endtask

    task automatic pop_cmp();
        exp_t e;
        if (sbq.size() == 0) begin
            check("sb_empty", 0, 1);
            return;
        end
        e = sbq.pop_front();
        check({e.tag, ".ce_low"}, m_ce - b_ce, e.ce);
        check({e.tag, ".oe_low"}, m_oe - b_oe, e.oe);
        check({e.tag, ".we_low"}, m_we - b_we, e.we);
        check({e.tag, ".done"}, m_done - b_done, e.dn);
        check({e.tag, ".error"}, m_err - b_err, e.er);
    endtask

    task automatic wait_state(input string tag, input logic [2:0] s, input int lim);
        int n = 0;
        while (SeqState !== s && n < lim) begin
            tick();
            n++;
        end
        check({tag, ".reach"}, int'(SeqState === s), 1);
    endtask

    task automatic setup_req(input logic rd, input logic [0:0] cs,
                             input logic [2:0] su, input logic [2:0] st,
                             input logic [2:0] ho);
        ReadSeq = rd; WriteSeq = ~rd; ChipSel = cs;
        SetupCnt = su; StrobeCnt = st; HoldCnt = ho;
    endtask

    initial begin
        #1 Reset_N = 1'b0;
        repeat (3) tick();
        check("rst.ce", int'(CE_N), 3);
        check("rst.we", int'(WE_N), 1);
        check("rst.oe", int'(OE_N), 1);
        check("rst.busy", int'(Busy), 0);
        check("rst.done", int'(Done), 0);
        check("rst.error", int'(Error), 0);
        check("rst.state", int'(SeqState), 0);
        Reset_N = 1'b1;
        tick();

        push("idle", 0, 0, 0, 0, 0);
        repeat (20) tick();
        check("idle.busy", m_busy - b_busy, 0);
        check("idle.state", int'(SeqState), 0);
        pop_cmp();

        push("noseq", 0, 0, 0, 0, 0);
        ReadSeq = 1'b0; WriteSeq = 1'b0; StartCycle = 1'b1;
        repeat (20) tick();
        check("noseq.busy", m_busy - b_busy, 0);
        StartCycle = 1'b0;
        tick();
        pop_cmp();

        // Read; request inputs changed mid-cycle must be ignored
        push("rd", 7, 6, 0, 1, 0);
        setup_req(1'b1, 1'b1, 3'd1, 3'd3, 3'd0);
        StartCycle = 1'b1;
        tick();
        check("rd.ce_sel", int'(CE_N), 1);
        check("rd.state_setup", int'(SeqState), 1);
        ReadSeq = 1'b0; WriteSeq = 1'b1; ChipSel = 1'b0; StrobeCnt = 3'd0;
        wait_state("rd.done", 3'd4, 40);
        repeat (5) tick();
        check("rd.done_hold", int'(SeqState), 4);
        StartCycle = 1'b0;
        tick();
        check("rd.back_idle", int'(SeqState), 0);
        pop_cmp();

        push("wr", 8, 0, 4, 1, 0);
        setup_req(1'b0, 1'b0, 3'd1, 3'd3, 3'd1);
        StartCycle = 1'b1;
        tick();
        check("wr.ce_sel", int'(CE_N), 2);
        wait_state("wr.done", 3'd4, 40);
        StartCycle = 1'b0;
        tick();
        check("wr.we_offset", m_we_fall - m_ce_fall, 2);
        pop_cmp();

        // Extend raised during strobe, dropped after 5 extra cycles
        push("ext_late", 12, 11, 0, 1, 0);
        setup_req(1'b1, 1'b0, 3'd1, 3'd3, 3'd0);
        StartCycle = 1'b1;
        repeat (3) tick();
        Extend = 1'b1;
        repeat (8) tick();
        Extend = 1'b0;
        wait_state("ext_late.done", 3'd4, 40);
        StartCycle = 1'b0;
        tick();
        pop_cmp();

        push("ext_early", 12, 11, 0, 1, 0);
        Extend = 1'b1;
        tick();
        StartCycle = 1'b1;
        repeat (11) tick();
        Extend = 1'b0;
        wait_state("ext_early.done", 3'd4, 40);
        StartCycle = 1'b0;
        tick();
        pop_cmp();

        push("both", 0, 0, 0, 0, 1);
        ReadSeq = 1'b1; WriteSeq = 1'b1; StartCycle = 1'b1;
        repeat (10) tick();
        check("both.state", int'(SeqState), 0);
        StartCycle = 1'b0;
        tick();
        pop_cmp();
        push("both_again", 0, 0, 0, 0, 1);
        StartCycle = 1'b1;
        repeat (5) tick();
        StartCycle = 1'b0;
        tick();
        pop_cmp();

        // Abort in strobe: full hold phase, then idle with no done
        push("abort", 6, 4, 0, 0, 0);
        setup_req(1'b1, 1'b0, 3'd1, 3'd3, 3'd1);
        StartCycle = 1'b1;
        repeat (4) tick();
        check("abort.in_strobe", int'(SeqState), 2);
        StartCycle = 1'b0;
        repeat (4) tick();
        check("abort.hold_cycles", m_hold - b_hold, 2);
        check("abort.idle", int'(SeqState), 0);
        pop_cmp();

        setup_req(1'b1, 1'b1, 3'd1, 3'd3, 3'd1);
        StartCycle = 1'b1;
        wait_state("arst.strobe", 3'd2, 20);
        #2 Reset_N = 1'b0;
        #1;
        check("arst.ce", int'(CE_N), 3);
        check("arst.oe", int'(OE_N), 1);
        check("arst.we", int'(WE_N), 1);
        check("arst.busy", int'(Busy), 0);
        check("arst.state", int'(SeqState), 0);
        StartCycle = 1'b0;
        tick();
        Reset_N = 1'b1;
        tick();

        check("invariants", m_inv, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nvram_seq_gen.md
Name: nvram_seq_gen

Overview:
Parametrised successor to the single-device NVRAM memory-cycle sequence generator. Produces active-low chip-enable, write-enable and output-enable strobes for one of NUM_CS NVRAM devices. Setup, strobe and hold phase lengths are programmable per cycle, and the strobe phase accepts an Extend wait-state input. Adds Busy/Done/Error handshake outputs and sits between the bus-cycle controller and the external NVRAM pins.

Parameters:
NUM_CS, 2, number of chip-enable outputs (1..8)
CS_W, 1, width of ChipSel index (clog2(NUM_CS), min 1)
CNT_W, 3, width of phase-length fields

Ports:
Clk  in  1  system clock; all state changes on rising edge
Reset_N  in  1  asynchronous, active-low reset
StartCycle  in  1  level; held high for the duration of a cycle request
ReadSeq  in  1  selects read sequence
WriteSeq  in  1  selects write sequence
ChipSel  in  CS_W  device index, latched at start
SetupCnt  in  CNT_W  setup phase length minus 1
StrobeCnt  in  CNT_W  strobe phase length minus 1 (successor of the former Delay input)
HoldCnt  in  CNT_W  hold phase length minus 1
Extend  in  1  wait-state request, sampled live during STROBE
CE_N  out  NUM_CS  chip enables, active low
WE_N  out  1  write enable, active low
OE_N  out  1  output enable, active low
Busy  out  1  high in SETUP/STROBE/HOLD
Done  out  1  one-cycle pulse on normal completion
Error  out  1  one-cycle pulse on illegal request
SeqState  out  3  current state encoding

Behaviour:
- All outputs registered and updated on the same edge as the state transition.
- Reset (Reset_N=0, async, any state): state IDLE, CE_N all 1, WE_N=1, OE_N=1, Busy=0, Done=0, Error=0, SeqState=0, counter=0.
- States and SeqState encoding: IDLE=0, SETUP=1, STROBE=2, HOLD=3, DONE=4.
- IDLE, with StartCycle=1 and exactly one of ReadSeq/WriteSeq=1:
  - latch mode, ChipSel and all three counts; load counter with SetupCnt; go to SETUP.
- IDLE, StartCycle=1, neither Seq set: stay in IDLE; all strobes inactive; no Error.
- IDLE, StartCycle=1, both Seq set: stay in IDLE; Error=1 for exactly one cycle; re-pulses only after StartCycle drops and is reasserted.
- ChipSel >= NUM_CS: treated as an illegal request, same handling as both-Seq (Error pulse, stay in IDLE).
- SETUP: CE_N[sel]=0. Read: OE_N=0. Write: WE_N=1. Lasts SetupCnt+1 cycles, then load counter with StrobeCnt and go to STROBE.
- STROBE: CE_N[sel]=0. Read: OE_N=0. Write: WE_N=0. Lasts StrobeCnt+1 cycles.
  - If Extend=1 when the counter reaches 0, stay in STROBE one more cycle per cycle Extend remains high.
  - On exit, load counter with HoldCnt and go to HOLD.
- HOLD: CE_N[sel]=0; WE_N=OE_N=1. Lasts HoldCnt+1 cycles, then go to DONE.
- DONE: all strobes inactive; Busy=0. Done=1 on the entry cycle only. Stay in DONE until StartCycle=0, then go to IDLE. No back-to-back cycle without StartCycle dropping.
- Abort (StartCycle=0 mid-cycle), no Done pulse in any case:
  - in SETUP: go to IDLE next edge.
  - in STROBE: go to HOLD and complete the full HoldCnt+1 cycles (data hold protected), then IDLE.
  - in HOLD: complete the phase, then IDLE.
- ReadSeq/WriteSeq/ChipSel/counts changing mid-cycle: ignored (latched values used).
- Invariants:
  - at most one CE_N bit low at a time;
  - WE_N and OE_N never low simultaneously;
  - WE_N low only while CE_N low.
- Nominal CE_N low width = (SetupCnt+1)+(StrobeCnt+1+extend cycles)+(HoldCnt+1).

Test Plan:
1. Reset, then 20 cycles with StartCycle=0 -> CE_N=2'b11, WE_N=1, OE_N=1, SeqState=0, Busy=0 throughout.
2. StartCycle=1, ReadSeq=WriteSeq=0 for 20 cycles, then StartCycle=0 -> no strobe ever low, Error=0, Done=0.
3. Read, ChipSel=1, Setup=1, Strobe=3, Hold=0 -> CE_N=2'b01 for 7 cycles, OE_N low 6 cycles, WE_N=1; Done pulses once; SeqState holds 4 until StartCycle=0.
4. Write, ChipSel=0, Setup=1, Strobe=3, Hold=1 -> CE_N=2'b10 for 8 cycles, WE_N low exactly 4 cycles starting 2 cycles after CE_N falls, OE_N=1.
5. Read, Strobe=3, Extend held high 5 cycles beyond the strobe terminal count -> OE_N low for 2+4+5 cycles; Done after HOLD. Repeat with Extend=1 before StartCycle -> same result.
6. Illegal/abort cases:
   - ReadSeq=WriteSeq=1 -> Error one cycle, no strobe.
   - StartCycle dropped in STROBE -> HOLD then IDLE, no Done.
   - Reset_N=0 mid-STROBE -> all outputs inactive immediately (before next Clk edge).
